// File: rtl/mul_seq.sv
// Sequential 32x32->64 long multiplier (UMULL/UMLAL/SMULL/SMLAL) with register-file write-back.
// Define MUL_SEQ_EARLY_TERM_EN to stop the shift-add loop once the remaining multiplier bits are zero.
module mul_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        Signed,
  input  logic        Accumulate,
  input  logic        SetFlags,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [31:0] AccHi,
  input  logic [31:0] AccLo,
  input  logic [3:0]  RdLo,
  input  logic [3:0]  RdHi,
  input  logic        Flush,
  output logic        Busy,
  output logic        WE3,
  output logic [3:0]  WA3,
  output logic [31:0] WD3,
  output logic        Done,
  output logic        FlagWrite,
  output logic [1:0]  NZ
);

  localparam int unsigned W  = 32;
  localparam int unsigned W2 = 2 * W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    WRLO = 2'd2,
    WRHI = 2'd3
  } state_t;

  state_t state_q, state_n;

  logic [W2-1:0] ma_q;
  logic [W-1:0]  mb_q;
  logic [W2-1:0] prod_q;
  logic [W2-1:0] acc_q;
  logic [W2-1:0] result_q;
  logic          neg_q;
  logic          accum_q;
  logic          setf_q;
  logic [3:0]    rdlo_q;
  logic [3:0]    rdhi_q;

  logic [W-1:0]  mag_a_c;
  logic [W-1:0]  mag_b_c;
  logic [W2-1:0] prod_step_c;
  logic [W2-1:0] prod_fix_c;
  logic [W2-1:0] res_c;
  logic          start_c;
  logic          last_step_c;

  // Operand magnitudes; 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign mag_a_c = (Signed && SrcA[W-1]) ? W'(~SrcA + W'(1)) : SrcA;
  assign mag_b_c = (Signed && SrcB[W-1]) ? W'(~SrcB + W'(1)) : SrcB;
  assign start_c = (state_q == IDLE) && Start && !Flush;

  // One radix-2 step, then sign fix-up and accumulate for the final step.
  assign prod_step_c = prod_q + (mb_q[0] ? ma_q : W2'(0));
  assign prod_fix_c  = neg_q ? W2'(~prod_step_c + W2'(1)) : prod_step_c;
  assign res_c       = prod_fix_c + (accum_q ? acc_q : W2'(0));

`ifdef MUL_SEQ_EARLY_TERM_EN
  assign last_step_c = (mb_q[W-1:1] == (W-1)'(0));
`else
  localparam int unsigned CW = $clog2(W);
  logic [CW-1:0] cnt_q;

  assign last_step_c = (cnt_q == CW'(W - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              cnt_q <= '0;
    else if (start_c)        cnt_q <= '0;
    else if (state_q == MUL) cnt_q <= cnt_q + CW'(1);
  end
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // Next-state logic; Flush wins over everything including Start
  always_comb begin
    state_n = state_q;
    if (Flush) begin
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (Start) state_n = MUL;
        MUL:     if (last_step_c) state_n = WRLO;
        WRLO:    state_n = WRHI;
        WRHI:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Operand capture and shift-add datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ma_q     <= '0;
      mb_q     <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      accum_q  <= 1'b0;
      setf_q   <= 1'b0;
      rdlo_q   <= '0;
      rdhi_q   <= '0;
    end else if (start_c) begin
      ma_q    <= W2'(mag_a_c);
      mb_q    <= mag_b_c;
      prod_q  <= '0;
      acc_q   <= {AccHi, AccLo};
      neg_q   <= Signed && (SrcA[W-1] ^ SrcB[W-1]);
      accum_q <= Accumulate;
      setf_q  <= SetFlags;
      rdlo_q  <= RdLo;
      rdhi_q  <= RdHi;
    end else if (state_q == MUL) begin
      prod_q <= prod_step_c;
      ma_q   <= ma_q << 1;
      mb_q   <= mb_q >> 1;
      if (last_step_c) result_q <= res_c;
    end
  end

  // Registered outputs, decoded from the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Busy      <= 1'b0;
      WE3       <= 1'b0;
      WA3       <= '0;
      WD3       <= '0;
      Done      <= 1'b0;
      FlagWrite <= 1'b0;
      NZ        <= '0;
    end else begin
      Busy      <= (state_n != IDLE);
      WE3       <= 1'b0;
      WA3       <= '0;
      WD3       <= '0;
      Done      <= 1'b0;
      FlagWrite <= 1'b0;
      if (state_n == WRLO) begin
        WE3 <= 1'b1;
        WA3 <= rdlo_q;
        WD3 <= res_c[W-1:0];
      end
      if (state_n == WRHI) begin
        WE3       <= 1'b1;
        WA3       <= rdhi_q;
        WD3       <= result_q[W2-1:W];
        Done      <= 1'b1;
        FlagWrite <= setf_q;
        NZ        <= {result_q[W2-1], (result_q == W2'(0))};
      end
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: stimulus pushes expected register writes, a monitor pops and checks them.
module tb_mul_seq;

  logic        clk;
  logic        reset;
  logic        Start;
  logic        Signed;
  logic        Accumulate;
  logic        SetFlags;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [31:0] AccHi;
  logic [31:0] AccLo;
  logic [3:0]  RdLo;
  logic [3:0]  RdHi;
  logic        Flush;
  logic        Busy;
  logic        WE3;
  logic [3:0]  WA3;
  logic [31:0] WD3;
  logic        Done;
  logic        FlagWrite;
  logic [1:0]  NZ;

  mul_seq dut (
    .clk(clk), .reset(reset), .Start(Start), .Signed(Signed), .Accumulate(Accumulate),
    .SetFlags(SetFlags), .SrcA(SrcA), .SrcB(SrcB), .AccHi(AccHi), .AccLo(AccLo),
    .RdLo(RdLo), .RdHi(RdHi), .Flush(Flush), .Busy(Busy), .WE3(WE3), .WA3(WA3),
    .WD3(WD3), .Done(Done), .FlagWrite(FlagWrite), .NZ(NZ)
  );

`ifdef MUL_SEQ_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    int          cyc;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        done;
    logic        fw;
    logic [1:0]  nz;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   ec    = 0;
  int   c0    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ec <= ec + 1;

  function automatic int mul_cycles(input logic sgn, input logic [31:0] b);
    logic [31:0] m;
    int n;
    m = (sgn && b[31]) ? (~b + 32'd1) : b;
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return EARLY ? n : 32;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every write/done/flag strobe must match the next queued expectation
  always @(negedge clk) begin
    if (reset && (WE3 || Done || FlagWrite)) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: WE3=%0b WA3=%0d WD3=0x%0h Done=%0b at ec %0d, expected no write",
                 WE3, WA3, WD3, Done, ec);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("write_cycle", 64'(ec), 64'(e.cyc));
        check("we3", 64'(WE3), 64'd1);
        check("wa3", 64'(WA3), 64'(e.wa));
        check("wd3", 64'(WD3), 64'(e.wd));
        check("done", 64'(Done), 64'(e.done));
        check("flagwrite", 64'(FlagWrite), 64'(e.fw));
        if (e.done) check("nz", 64'(NZ), 64'(e.nz));
      end
    end
  end

  // Drive one Start in cycle 0, then scramble inputs; returns in cycle 1
  task automatic issue(input logic sgn, input logic acc, input logic sf,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ahi, input logic [31:0] alo,
                       input logic [3:0] rl, input logic [3:0] rh);
    @(negedge clk);
    Start = 1'b1; Signed = sgn; Accumulate = acc; SetFlags = sf;
    SrcA = a; SrcB = b; AccHi = ahi; AccLo = alo; RdLo = rl; RdHi = rh;
    c0 = ec;
    @(negedge clk);
    Start = 1'b0; Signed = ~sgn; Accumulate = ~acc; SetFlags = ~sf;
    SrcA = $urandom; SrcB = $urandom; AccHi = $urandom; AccLo = $urandom;
    RdLo = ~rl; RdHi = ~rh;
    check("busy_cycle1", 64'(Busy), 64'd1);
  endtask

  task automatic run_op(input logic sgn, input logic acc, input logic sf,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ahi, input logic [31:0] alo,
                        input logic [3:0] rl, input logic [3:0] rh,
                        input logic [31:0] lo, input logic [31:0] hi, input logic [1:0] nz);
    int lat;
    lat = mul_cycles(sgn, b);
    issue(sgn, acc, sf, a, b, ahi, alo, rl, rh);
    q.push_back('{cyc: c0 + lat + 1, wa: rl, wd: lo, done: 1'b0, fw: 1'b0, nz: 2'b00});
    q.push_back('{cyc: c0 + lat + 2, wa: rh, wd: hi, done: 1'b1, fw: sf, nz: nz});
    repeat (lat + 2) @(negedge clk);
    check("busy_after_done", 64'(Busy), 64'd0);
    check("queue_drained", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int lat;
    int guard;
    reset = 1'b0; Start = 1'b0; Signed = 1'b0; Accumulate = 1'b0; SetFlags = 1'b0;
    SrcA = '0; SrcB = '0; AccHi = '0; AccLo = '0; RdLo = '0; RdHi = '0; Flush = 1'b0;
    #1;
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_outs", {WE3, WA3, WD3, Done, FlagWrite, NZ}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Directed vectors with hand-computed results
    run_op(0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 4'd1, 4'd2, 32'h00000001, 32'hFFFFFFFE, 2'b10);
    run_op(1, 0, 1, 32'hFFFFFFFE, 32'h00000003, 0, 0, 4'd3, 4'd4, 32'hFFFFFFFA, 32'hFFFFFFFF, 2'b10);
    run_op(1, 1, 0, 32'h80000000, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 4'd5, 4'd6,
           32'hFFFFFFFF, 32'h40000001, 2'b00);
    run_op(0, 0, 1, 32'd5, 32'd1, 0, 0, 4'd7, 4'd8, 32'h00000005, 32'h00000000, 2'b00);
    run_op(0, 0, 0, 32'h12345678, 32'h00000010, 0, 0, 4'd9, 4'd9, 32'h23456780, 32'h00000001, 2'b00);
    run_op(0, 0, 1, 32'd0, 32'h00001234, 0, 0, 4'd12, 4'd13, 32'h00000000, 32'h00000000, 2'b01);
    run_op(1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 4'd14, 4'd15, 32'h00000001, 32'h00000000, 2'b00);
    run_op(0, 1, 1, 32'd2, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFC, 4'd0, 4'd1, 32'h00000002, 32'h00000000, 2'b00);

    // Reset in MUL cycle 10: no write may follow
    issue(0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 4'd1, 4'd2);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_busy", 64'(Busy), 64'd0);
    check("rst_mid_we3", 64'(WE3), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_op(0, 0, 0, 32'h00010000, 32'h00010000, 0, 0, 4'd3, 4'd4, 32'h00000000, 32'h00000001, 2'b00);

    // Start while busy is ignored; Flush in WRLO leaves only the low-word write
    lat = mul_cycles(1'b0, 32'd9);
    issue(0, 0, 1, 32'd7, 32'd9, 0, 0, 4'd10, 4'd11);
    q.push_back('{cyc: c0 + lat + 1, wa: 4'd10, wd: 32'd63, done: 1'b0, fw: 1'b0, nz: 2'b00});
    guard = 0;
    while (ec != c0 + 5 && guard < 100) begin @(negedge clk); guard++; end
    Start = 1'b1; Signed = 1'b1; SrcA = 32'hDEADBEEF; SrcB = 32'h00000002; RdLo = 4'd2; RdHi = 4'd3;
    @(negedge clk);
    Start = 1'b0;
    check("busy_after_ignored_start", 64'(Busy), 64'(lat > 5));
    guard = 0;
    while (ec != c0 + lat + 1 && guard < 100) begin @(negedge clk); guard++; end
    check("reach_wrlo", 64'(ec), 64'(c0 + lat + 1));
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    check("flush_busy", 64'(Busy), 64'd0);
    check("flush_done", 64'(Done), 64'd0);
    repeat (3) @(negedge clk);
    check("flush_queue", 64'(q.size()), 64'd0);

    // Flush beats Start in IDLE
    @(negedge clk);
    Start = 1'b1; Flush = 1'b1;
    @(negedge clk);
    Start = 1'b0; Flush = 1'b0;
    check("flush_over_start", 64'(Busy), 64'd0);
    repeat (40) @(negedge clk);
    check("final_queue", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
